chip_serial_capture: RTL and testbench

//  Per-stream serial-to-parallel capture for the chip eval result streams (ADC, mag, phase,

---
 rtl/chip_capture_pkg.sv | 12 +
 rtl/sync_fifo.sv | 57 +++++
 rtl/chip_serial_capture.sv | 86 ++++++++
 tb/tb_chip_serial_capture.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/chip_capture_pkg.sv
// Shared defaults and level-width helper for the chip serial capture instances
// and the PS-side register map.
package chip_capture_pkg;
  localparam int WORD_W_DEF = 16;
  localparam int DEPTH_DEF  = 16;
  localparam int CNT_W_DEF  = 16;

  // A FIFO of DEPTH words needs one extra bit to represent "exactly full".
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO: head word is visible on rdata whenever non-empty.
// Pop on empty is ignored; push on full succeeds only when a pop frees a slot.
module sync_fifo
  import chip_capture_pkg::*;
#(
  parameter int WIDTH = WORD_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      push,
  input  logic [WIDTH-1:0]          wdata,
  input  logic                      pop,
  output logic [WIDTH-1:0]          rdata,
  output logic                      full,
  output logic                      empty,
  output logic [lvl_w(DEPTH)-1:0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = lvl_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Gate the head so an empty FIFO reads as zero rather than stale storage.
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/chip_serial_capture.sv
// Per-stream serial-to-parallel capture: MSB-first word assembly with flush of
// partial words, feeding a show-ahead FIFO drained by the PS.
module chip_serial_capture
  import chip_capture_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     ser_data,
  input  logic                     ser_valid,
  input  logic                     flush,
  input  logic                     rd_en,
  output logic [WORD_W-1:0]        rd_data,
  output logic                     rd_valid,
  output logic [lvl_w(DEPTH)-1:0]  fifo_level,
  output logic                     overflow,
  output logic                     partial,
  output logic [CNT_W-1:0]         words_captured
);
  localparam int BW = $clog2(WORD_W);
  localparam int CW = BW + 1;

  logic [WORD_W-1:0] shreg, sh_nxt, push_data;
  logic [BW-1:0]     bitcnt;
  logic [CW-1:0]     cnt_nxt;
  logic              word_done, part_push, push;
  logic              fifo_full, fifo_empty;

  always_comb begin
    sh_nxt    = ser_valid ? {shreg[WORD_W-2:0], ser_data} : shreg;
    cnt_nxt   = {1'b0, bitcnt} + CW'(ser_valid);
    word_done = ser_valid && (bitcnt == BW'(WORD_W - 1));
    // A same-cycle completing bit wins over flush: one full word, no partial.
    part_push = flush && !word_done && (cnt_nxt != '0);
    push      = word_done || part_push;
    push_data = word_done ? sh_nxt : (sh_nxt << (CW'(WORD_W) - cnt_nxt));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg          <= '0;
      bitcnt         <= '0;
      overflow       <= 1'b0;
      partial        <= 1'b0;
      words_captured <= '0;
    end else if (clear) begin
      shreg          <= '0;
      bitcnt         <= '0;
      overflow       <= 1'b0;
      partial        <= 1'b0;
      words_captured <= '0;
    end else begin
      if (push) begin
        shreg  <= '0;
        bitcnt <= '0;
      end else begin
        shreg  <= sh_nxt;
        bitcnt <= cnt_nxt[BW-1:0];
      end
      // Full implies non-empty, so a same-cycle rd_en always frees a slot.
      if (push && fifo_full && !rd_en) overflow <= 1'b1;
      if (part_push) partial <= 1'b1;
      if (push && (!fifo_full || rd_en) && (words_captured != '1))
        words_captured <= words_captured + 1'b1;
    end
  end

  sync_fifo #(.WIDTH(WORD_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (clear),
    .push  (push),
    .wdata (push_data),
    .pop   (rd_en),
    .rdata (rd_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign rd_valid = !fifo_empty;
endmodule

// File: tb/tb_chip_serial_capture.sv
// Scoreboard bench: a bit-queue reference model predicts accepted words and
// flags; a negedge monitor checks the FIFO head against the expected queue.
module tb_chip_serial_capture;
  localparam int W     = 16;
  localparam int D     = 16;
  localparam int CNT_W = 16;
  localparam int LW    = $clog2(D) + 1;

  logic          clk = 0, rst = 1, clear = 0, ser_data = 0, ser_valid = 0, flush = 0, rd_en = 0;
  logic [W-1:0]  rd_data;
  logic          rd_valid, overflow, partial;
  logic [LW-1:0] fifo_level;
  logic [CNT_W-1:0] words_captured;

  chip_serial_capture #(.WORD_W(W), .DEPTH(D), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .clear(clear), .ser_data(ser_data), .ser_valid(ser_valid),
    .flush(flush), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .fifo_level(fifo_level), .overflow(overflow), .partial(partial),
    .words_captured(words_captured)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  // Reference model state
  bit         bq[$];
  logic [W-1:0] exp_q[$];
  int         mlvl = 0;
  bit         mover = 0, mpart = 0;
  longint     mcnt = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] pack_bits();
    logic [W-1:0] w = '0;
    foreach (bq[i]) w[W-1-i] = bq[i];
    return w;
  endfunction

  task automatic model_reset();
    bq.delete(); exp_q.delete();
    mlvl = 0; mover = 0; mpart = 0; mcnt = 0;
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_rd_valid"}, rd_valid, mlvl > 0);
    chk({tag, "_level"}, fifo_level, mlvl);
    chk({tag, "_overflow"}, overflow, mover);
    chk({tag, "_partial"}, partial, mpart);
    chk({tag, "_words"}, words_captured, mcnt);
    if (mlvl == 0) chk({tag, "_rd_data_idle"}, rd_data, 0);
  endtask

  task automatic step(input bit sv, input bit sd, input bit fl, input bit rd, input bit cl = 0);
    logic [W-1:0] w;
    bit have, part, pop;
    ser_valid = sv; ser_data = sd; flush = fl; rd_en = rd; clear = cl;
    if (cl) model_reset();
    else begin
      have = 0; part = 0; w = '0;
      if (sv) bq.push_back(sd);
      if (bq.size() == W) begin w = pack_bits(); have = 1; bq.delete(); end
      else if (fl && bq.size() > 0) begin w = pack_bits(); have = 1; part = 1; bq.delete(); end
      pop = rd && (mlvl > 0);
      if (have) begin
        if (part) mpart = 1;
        if (mlvl == D && !pop) mover = 1;
        else begin
          exp_q.push_back(w);
          mlvl++;
          if (mcnt != (64'd1 << CNT_W) - 1) mcnt++;
        end
      end
      if (pop) mlvl--;
    end
    @(posedge clk); #1;
    ser_valid = 0; flush = 0; rd_en = 0; clear = 0;
    check_state("step");
  endtask

  // Shift a word MSB-first with random idle gaps; optional rd/flush on the last bit.
  task automatic send_word(input logic [W-1:0] w, input bit last_rd = 0, input bit last_fl = 0);
    for (int i = W - 1; i >= 0; i--) begin
      int gaps = $urandom_range(0, 2);
      for (int g = 0; g < gaps; g++) step(0, 0, 0, 0);
      step(1, w[i], (i == 0) ? last_fl : 1'b0, (i == 0) ? last_rd : 1'b0);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < D + 2 && mlvl > 0; i++) step(0, 0, 0, 1);
    chk("drain_empty", rd_valid, 0);
  endtask

  always @(negedge clk) begin
    if (!rst && !clear && rd_valid) begin
      if (exp_q.size() == 0) chk("sb_unexpected_word", rd_data, 'hFFFF_FFFF);
      else begin
        chk("sb_head", rd_data, exp_q[0]);
        if (rd_en) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [W-1:0] words[D+1];
    #12 rst = 0;
    @(posedge clk); #1;
    check_state("reset");

    // 1: single word with gaps
    send_word(16'hA5C3);
    chk("t1_data", rd_data, 16'hA5C3);
    chk("t1_level", fifo_level, 1);
    chk("t1_words", words_captured, 1);
    drain();

    // 2: 5-bit partial flush, then empty flush
    step(1, 1, 0, 0); step(1, 0, 0, 0); step(0, 0, 0, 0);
    step(1, 1, 0, 0); step(1, 1, 0, 0); step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    chk("t2_data", rd_data, 16'hB000);
    chk("t2_partial", partial, 1);
    step(0, 0, 1, 0);
    chk("t2_empty_flush_level", fifo_level, 1);
    drain();

    // 3: overflow on 17th push, then 17th push with same-cycle read
    step(0, 0, 0, 0, 1);
    for (int i = 0; i <= D; i++) begin words[i] = W'($urandom); send_word(words[i]); end
    chk("t3_level", fifo_level, 16);
    chk("t3_overflow", overflow, 1);
    chk("t3_words", words_captured, 16);
    chk("t3_head", rd_data, words[0]);
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < D; i++) send_word(W'($urandom));
    send_word(16'h1234, 1);
    chk("t3_rd_overflow", overflow, 0);
    chk("t3_rd_level", fifo_level, 16);

    // 4: drain through wrap; rd_en on empty
    drain();
    step(0, 0, 0, 1);
    chk("t4_empty_rd_level", fifo_level, 0);

    // 5: async reset mid-word, clean word afterwards, clear with flags set
    for (int i = 0; i < 9; i++) step(1, i[0], 0, 0);
    @(posedge clk); #3 rst = 1; #1;
    model_reset();
    check_state("t5_rst");
    #3 rst = 0;
    @(posedge clk); #1;
    send_word(16'h5A3C);
    chk("t5_clean", rd_data, 16'h5A3C);
    drain();
    step(1, 1, 0, 0); step(1, 1, 0, 0); step(1, 0, 1, 0);
    for (int i = 0; i < D; i++) send_word(W'($urandom));
    chk("t5_pre_over", overflow, 1);
    chk("t5_pre_part", partial, 1);
    step(0, 0, 0, 0, 1);
    chk("t5_clr_level", fifo_level, 0);
    chk("t5_clr_flags", {overflow, partial}, 0);

    // 6: last bit + flush together
    send_word(16'h0F0F, 0, 1);
    chk("t6_level", fifo_level, 1);
    chk("t6_partial", partial, 0);
    chk("t6_data", rd_data, 16'h0F0F);
    drain();

    // Random phase
    for (int i = 0; i < 4000; i++) begin
      int rdp = (i < 2000) ? 6 : 2;
      step($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 40) == 0,
           $urandom_range(0, rdp) == 0, $urandom_range(0, 700) == 0);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
